sync_fifo_param: RTL and testbench

SYNC_FIFO_PARAM -- requirements
Module: sync_fifo_param

---
 rtl/sync_fifo_param.sv | 115 +++++++++++
 tb/tb_sync_fifo_param.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_param.sv
// Single-clock parameterised FIFO with occupancy count, threshold flags and sticky errors.
// Supports registered-read (FWFT=0) and first-word-fall-through (FWFT=1) output styles.
module sync_fifo_param #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2,
    parameter int FWFT     = 0
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    input  logic                     err_clr,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] AF_CNT   = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_CNT   = CW'(AE_LEVEL);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wrPtr;
    logic [AW-1:0]    r_rdPtr;
    logic [CW-1:0]    r_count;
    logic             r_overflow;
    logic             r_underflow;

    logic w_full;
    logic w_empty;
    logic w_wrAccept;
    logic w_rdAccept;

    assign w_full     = (r_count == FULL_CNT);
    assign w_empty    = (r_count == '0);
    assign w_wrAccept = wr_en && !w_full;
    assign w_rdAccept = rd_en && !w_empty;

    assign count        = r_count;
    assign full         = w_full;
    assign empty        = w_empty;
    assign almost_full  = (r_count >= AF_CNT);
    assign almost_empty = (r_count <= AE_CNT);
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

    // Storage is deliberately left out of reset so it maps onto plain RAM.
    always_ff @(posedge clock) begin
        if (!reset && w_wrAccept) begin
            r_mem[r_wrPtr] <= wr_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wrPtr     <= '0;
            r_rdPtr     <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wrAccept) begin
                r_wrPtr <= r_wrPtr + AW'(1);
            end
            if (w_rdAccept) begin
                r_rdPtr <= r_rdPtr + AW'(1);
            end
            case ({w_wrAccept, w_rdAccept})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            // A fresh error wins over a coincident clear.
            if (wr_en && w_full) begin
                r_overflow <= 1'b1;
            end else if (err_clr) begin
                r_overflow <= 1'b0;
            end
            if (rd_en && w_empty) begin
                r_underflow <= 1'b1;
            end else if (err_clr) begin
                r_underflow <= 1'b0;
            end
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign rd_data = w_empty ? '0 : r_mem[r_rdPtr];
        end else begin : g_regRead
            logic [WIDTH-1:0] r_rdData;

            always_ff @(posedge clock) begin
                if (reset) begin
                    r_rdData <= '0;
                end else if (w_rdAccept) begin
                    r_rdData <= r_mem[r_rdPtr];
                end
            end

            assign rd_data = r_rdData;
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param: a queue scoreboard checks the registered-read instance,
// a second instance exercises first-word-fall-through and mid-operation reset.
module tb_sync_fifo_param;

    logic       clock;
    logic       reset;
    logic       wrEn;
    logic [7:0] wrData;
    logic       rdEn;
    logic       errClr;
    logic [7:0] rdData;
    logic [4:0] count;
    logic       full;
    logic       empty;
    logic       almostFull;
    logic       almostEmpty;
    logic       overflow;
    logic       underflow;

    logic       resetF;
    logic       wrEnF;
    logic [7:0] wrDataF;
    logic       rdEnF;
    logic       errClrF;
    logic [7:0] rdDataF;
    logic [4:0] countF;
    logic       fullF;
    logic       emptyF;
    logic       almostFullF;
    logic       almostEmptyF;
    logic       overflowF;
    logic       underflowF;

    int errors = 0;
    int checks = 0;

    logic [7:0] expQ[$];
    int         mCount;
    logic [7:0] mRdData;
    logic       mOverflow;
    logic       mUnderflow;

    int         wrote;
    logic       weSel;
    logic       reSel;

    sync_fifo_param #(.WIDTH(8), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(0)) dut (
        .clock(clock), .reset(reset), .wr_en(wrEn), .wr_data(wrData), .rd_en(rdEn),
        .err_clr(errClr), .rd_data(rdData), .count(count), .full(full), .empty(empty),
        .almost_full(almostFull), .almost_empty(almostEmpty),
        .overflow(overflow), .underflow(underflow)
    );

    sync_fifo_param #(.WIDTH(8), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(1)) dutF (
        .clock(clock), .reset(resetF), .wr_en(wrEnF), .wr_data(wrDataF), .rd_en(rdEnF),
        .err_clr(errClrF), .rd_data(rdDataF), .count(countF), .full(fullF), .empty(emptyF),
        .almost_full(almostFullF), .almost_empty(almostEmptyF),
        .overflow(overflowF), .underflow(underflowF)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkVal(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One clock of stimulus on the registered-read instance; the model mirrors the behaviour
    // described for the FIFO, with the scoreboard queue holding words not yet popped.
    task automatic applyStimulus(input logic we, input logic [7:0] wd, input logic re,
                                 input logic clr, input logic rst);
        logic wAcc;
        logic rAcc;
        wrEn   = we;
        wrData = wd;
        rdEn   = re;
        errClr = clr;
        reset  = rst;
        wAcc   = we && (mCount < 16);
        rAcc   = re && (mCount > 0);
        @(posedge clock);
        #1;
        if (rst) begin
            mCount     = 0;
            expQ.delete();
            mRdData    = 8'h00;
            mOverflow  = 1'b0;
            mUnderflow = 1'b0;
        end else begin
            if (we && mCount == 16) mOverflow = 1'b1;
            else if (clr)           mOverflow = 1'b0;
            if (re && mCount == 0)  mUnderflow = 1'b1;
            else if (clr)           mUnderflow = 1'b0;
            if (rAcc) begin
                mRdData = expQ.pop_front();
                mCount--;
            end
            if (wAcc) begin
                expQ.push_back(wd);
                mCount++;
            end
        end
        wrEn   = 1'b0;
        rdEn   = 1'b0;
        errClr = 1'b0;
        reset  = 1'b0;
    endtask

    task automatic checkOutput(input string tag);
        checkVal({tag, ".rd_data"}, 64'(rdData), 64'(mRdData));
        checkVal({tag, ".count"}, 64'(count), 64'(mCount));
        checkVal({tag, ".overflow"}, 64'(overflow), 64'(mOverflow));
        checkVal({tag, ".underflow"}, 64'(underflow), 64'(mUnderflow));
    endtask

    task automatic checkFlags(input string tag);
        checkVal({tag, ".full"}, 64'(full), 64'(mCount == 16));
        checkVal({tag, ".empty"}, 64'(empty), 64'(mCount == 0));
        checkVal({tag, ".almost_full"}, 64'(almostFull), 64'(mCount >= 14));
        checkVal({tag, ".almost_empty"}, 64'(almostEmpty), 64'(mCount <= 2));
    endtask

    task automatic stepF(input logic we, input logic [7:0] wd, input logic re, input logic rst);
        wrEnF   = we;
        wrDataF = wd;
        rdEnF   = re;
        resetF  = rst;
        @(posedge clock);
        #1;
        wrEnF  = 1'b0;
        rdEnF  = 1'b0;
        resetF = 1'b0;
    endtask

    initial begin
        wrEn = 1'b0; wrData = 8'h00; rdEn = 1'b0; errClr = 1'b0; reset = 1'b1;
        wrEnF = 1'b0; wrDataF = 8'h00; rdEnF = 1'b0; errClrF = 1'b0; resetF = 1'b1;
        mCount = 0; mRdData = 8'h00; mOverflow = 1'b0; mUnderflow = 1'b0;

        // Reset state of both instances.
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        stepF(1'b0, 8'h00, 1'b0, 1'b1);
        checkOutput("reset");
        checkFlags("reset");
        checkVal("resetF.empty", 64'(emptyF), 64'(1));
        checkVal("resetF.rd_data", 64'(rdDataF), 64'(0));
        checkVal("resetF.count", 64'(countF), 64'(0));
        checkVal("resetF.flags", 64'({fullF, almostFullF, almostEmptyF, overflowF, underflowF}), 64'(5'b00100));

        // Underflow: sticky, survives a coincident clear, cleared on its own.
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        checkOutput("underflow.set");
        checkVal("underflow.flag", 64'(underflow), 64'(1));
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        checkOutput("underflow.clrCollide");
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        checkOutput("underflow.clr");
        checkVal("underflow.cleared", 64'(underflow), 64'(0));

        // Fill one word at a time, checking every threshold on the way up.
        for (int i = 1; i <= 16; i++) begin
            applyStimulus(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
            checkOutput("fill");
            checkFlags("fill");
        end
        checkVal("fill.full", 64'(full), 64'(1));

        // Full with both requests: read wins, write rejected, overflow set.
        applyStimulus(1'b1, 8'h77, 1'b1, 1'b0, 1'b0);
        checkOutput("fullBoth");
        checkVal("fullBoth.count", 64'(count), 64'(15));
        checkVal("fullBoth.overflow", 64'(overflow), 64'(1));
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        checkOutput("overflow.clr");

        // Drain; scoreboard expects 0x02..0x10 in order with 1-cycle latency.
        while (mCount > 0) begin
            applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
            checkOutput("drain");
        end
        checkFlags("drained");
        checkVal("drained.rd_data", 64'(rdData), 64'(8'h10));

        // Simultaneous write and read at count 5 for 8 cycles.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 8'(8'h20 + i), 1'b0, 1'b0, 1'b0);
        end
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 8'(8'h30 + i), 1'b1, 1'b0, 1'b0);
            checkOutput("simul");
        end
        checkVal("simul.count", 64'(count), 64'(5));
        while (mCount > 0) begin
            applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
            checkOutput("simulDrain");
        end

        // Empty with both requests: write wins, underflow set.
        applyStimulus(1'b1, 8'h5A, 1'b1, 1'b0, 1'b0);
        checkOutput("emptyBoth");
        checkVal("emptyBoth.count", 64'(count), 64'(1));
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        checkOutput("emptyBoth.pop");

        // Wrap-around: 40 writes of an incrementing pattern, occupancy held in 3..12.
        wrote = 0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 8'(8'h40 + wrote), 1'b0, 1'b0, 1'b0);
            wrote++;
        end
        for (int i = 0; i < 400 && wrote < 40; i++) begin
            weSel = (mCount < 12) && (i % 3 != 2);
            reSel = (mCount > 3) && (i % 2 == 0);
            applyStimulus(weSel, 8'(8'h40 + wrote), reSel, 1'b0, 1'b0);
            if (weSel) wrote++;
            checkOutput("wrap");
        end
        checkVal("wrap.written", 64'(wrote), 64'(40));
        while (mCount > 0) begin
            applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
            checkOutput("wrapDrain");
        end
        checkVal("wrap.lastWord", 64'(rdData), 64'(8'h40 + 39));

        // Reset at count 7 beats coincident write/read/clear; first access afterwards is accepted.
        for (int i = 0; i < 7; i++) begin
            applyStimulus(1'b1, 8'(8'h90 + i), 1'b0, 1'b0, 1'b0);
        end
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        checkVal("preReset.rd_data", 64'(rdData), 64'(8'h90));
        applyStimulus(1'b1, 8'hEE, 1'b1, 1'b1, 1'b1);
        checkOutput("midReset");
        checkFlags("midReset");
        applyStimulus(1'b1, 8'hC3, 1'b0, 1'b0, 1'b0);
        checkOutput("postReset");
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        checkOutput("postReset.read");

        // First-word-fall-through instance.
        stepF(1'b1, 8'hA5, 1'b0, 1'b0);
        checkVal("fwft.rd_data", 64'(rdDataF), 64'(8'hA5));
        checkVal("fwft.empty", 64'(emptyF), 64'(0));
        for (int i = 1; i < 7; i++) begin
            stepF(1'b1, 8'(8'hB0 + i), 1'b0, 1'b0);
        end
        checkVal("fwft.count7", 64'(countF), 64'(7));
        checkVal("fwft.head", 64'(rdDataF), 64'(8'hA5));
        stepF(1'b0, 8'h00, 1'b1, 1'b0);
        checkVal("fwft.pop", 64'(rdDataF), 64'(8'hB1));
        stepF(1'b1, 8'h11, 1'b0, 1'b0);
        checkVal("fwft.count7b", 64'(countF), 64'(7));
        stepF(1'b1, 8'h22, 1'b1, 1'b1);
        checkVal("fwftReset.count", 64'(countF), 64'(0));
        checkVal("fwftReset.empty", 64'(emptyF), 64'(1));
        checkVal("fwftReset.rd_data", 64'(rdDataF), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
